// File: rtl/pll_ctrl_pkg.sv
// Shared encodings for the PLL integral-path gain scheduler: gear codes,
// evaluation phase and the integral step width.
package pll_ctrl_pkg;

  localparam int KI_W = 20;

  localparam logic [1:0] GEAR_WIDE   = 2'd0;
  localparam logic [1:0] GEAR_MID    = 2'd1;
  localparam logic [1:0] GEAR_NARROW = 2'd2;

  typedef enum logic {
    EVAL = 1'b0,
    HOLD = 1'b1
  } phase_t;

endpackage

// File: rtl/loop_gain_scheduler_if.sv
// Scheduler bus: PD sample stream and enable in, gear/step/lock status out.
// Handshake: a sample is taken on a rising clk edge where en && pd_valid; there is no ready.
interface loop_gain_scheduler_if;
  import pll_ctrl_pkg::*;

  logic            en;
  logic            pd_x;
  logic            pd_valid;
  logic [KI_W-1:0] ki_step;
  logic [1:0]      gear;
  logic            locked;
  logic            gear_chg;
  phase_t          phase;     // FSM state, exposed for checkers

  modport master (
    output en, pd_x, pd_valid,
    input  ki_step, gear, locked, gear_chg, phase
  );

  modport slave (
    input  en, pd_x, pd_valid,
    output ki_step, gear, locked, gear_chg, phase
  );

endinterface

// File: rtl/toggle_window_counter.sv
// Counts accepted PD samples and PD toggles over a fixed window; pulses win_done
// on the closing sample with the window's total toggle count (including that sample).
module toggle_window_counter #(
  parameter int WIN_LEN = 256,
  parameter int CW      = $clog2(WIN_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample,
  input  logic          pd_x,
  input  logic          clear,
  output logic          win_done,
  output logic [CW-1:0] toggles
);

  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] toggle_cnt;
  logic          prev_x;
  logic          first;
  logic          tog;

  // The first sample of a window has no predecessor to toggle against.
  assign tog      = sample && !first && (pd_x != prev_x);
  assign toggles  = toggle_cnt + {{(CW-1){1'b0}}, tog};
  assign win_done = sample && (sample_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      toggle_cnt <= '0;
      prev_x     <= 1'b0;
      first      <= 1'b1;
    end else if (clear) begin
      sample_cnt <= '0;
      toggle_cnt <= '0;
      first      <= 1'b1;
    end else if (sample) begin
      prev_x <= pd_x;
      if (win_done) begin
        sample_cnt <= '0;
        toggle_cnt <= '0;
        first      <= 1'b1;
      end else begin
        sample_cnt <= sample_cnt + 1'b1;
        toggle_cnt <= toggles;
        first      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/loop_gain_scheduler.sv
// Gear-shifting controller for the PLL integral path: steps WIDE->MID->NARROW on
// busy PD windows, drops straight to WIDE on quiet ones, then settles before re-evaluating.
module loop_gain_scheduler
  import pll_ctrl_pkg::*;
#(
  parameter int KI_WIDE   = 10000,
  parameter int KI_MID    = 2500,
  parameter int KI_NARROW = 625,
  parameter int WIN_LEN   = 256,
  parameter int TOGGLE_HI = 96,
  parameter int TOGGLE_LO = 32,
  parameter int SETTLE    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  loop_gain_scheduler_if.slave bus
);

  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int HW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] HI_C      = CW'(TOGGLE_HI);
  localparam logic [CW-1:0] LO_C      = CW'(TOGGLE_LO);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE - 1);

  phase_t        phase_q, phase_n;
  logic [1:0]    gear_q, gear_n;
  logic [HW-1:0] hold_q, hold_n;
  logic          chg_q, chg_n;
  logic          accept;
  logic          cnt_sample, cnt_clear;
  logic          win_done;
  logic [CW-1:0] toggles;

  assign accept = bus.en && bus.pd_valid;

  toggle_window_counter #(.WIN_LEN(WIN_LEN), .CW(CW)) u_win (
    .clk      (clk),
    .rst      (rst),
    .sample   (cnt_sample),
    .pd_x     (bus.pd_x),
    .clear    (cnt_clear),
    .win_done (win_done),
    .toggles  (toggles)
  );

  always_comb begin
    phase_n    = phase_q;
    gear_n     = gear_q;
    hold_n     = hold_q;
    chg_n      = 1'b0;
    cnt_sample = 1'b0;
    cnt_clear  = 1'b0;
    case (phase_q)
      EVAL: begin
        cnt_sample = accept;
        if (win_done) begin
          if (toggles >= HI_C && gear_q != GEAR_NARROW) begin
            gear_n = gear_q + 2'd1;
            chg_n  = 1'b1;
          end else if (toggles < LO_C && gear_q != GEAR_WIDE) begin
            gear_n = GEAR_WIDE;
            chg_n  = 1'b1;
          end
          if (chg_n) begin
            phase_n = HOLD;
            hold_n  = '0;
          end
        end
      end
      HOLD: begin
        // Samples here only age the settle timer; PD statistics are not gathered.
        if (accept) begin
          if (hold_q == HOLD_LAST) begin
            phase_n   = EVAL;
            hold_n    = '0;
            cnt_clear = 1'b1;
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
      end
      default: phase_n = EVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= EVAL;
      gear_q  <= GEAR_WIDE;
      hold_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      phase_q <= phase_n;
      gear_q  <= gear_n;
      hold_q  <= hold_n;
      chg_q   <= chg_n;
    end
  end

  always_comb begin
    case (gear_q)
      GEAR_MID:    bus.ki_step = KI_W'(KI_MID);
      GEAR_NARROW: bus.ki_step = KI_W'(KI_NARROW);
      default:     bus.ki_step = KI_W'(KI_WIDE);
    endcase
  end

  assign bus.gear     = gear_q;
  assign bus.locked   = (gear_q == GEAR_NARROW);
  assign bus.gear_chg = chg_q;
  assign bus.phase    = phase_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Directed bench for loop_gain_scheduler with WIN_LEN=16, TOGGLE_HI=8, TOGGLE_LO=2, SETTLE=4.
module tb_loop_gain_scheduler;
  import pll_ctrl_pkg::*;

  localparam int WIN = 16;
  localparam int SET = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  loop_gain_scheduler_if bus ();

  loop_gain_scheduler #(
    .KI_WIDE(10000), .KI_MID(2500), .KI_NARROW(625),
    .WIN_LEN(WIN), .TOGGLE_HI(8), .TOGGLE_LO(2), .SETTLE(SET)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [22:0] pack(logic [1:0] g, int ki, logic lk);
    return {g, KI_W'(ki), lk};
  endfunction

  // Monitor: every gear_chg pulse must match the next expected gear change.
  always @(negedge clk) begin
    if (!rst && bus.gear_chg) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_gear_chg: got gear %0d, expected no change", bus.gear);
      end else begin
        check("gear_chg_state", int'({bus.gear, bus.ki_step, bus.locked}),
              int'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset(int cycles);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.pd_valid = 1'b0;
    bus.pd_x = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_ki_step", int'(bus.ki_step), 10000);
    check("rst_gear", int'(bus.gear), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_gear_chg", int'(bus.gear_chg), 0);
    check("rst_phase", int'(bus.phase), int'(EVAL));
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic x);
    bus.en = 1'b1;
    bus.pd_valid = 1'b1;
    bus.pd_x = x;
    @(posedge clk);
    #1;
    bus.pd_valid = 1'b0;
  endtask

  // Idle cycles that must not be accepted: pd_valid gaps or en=0 with junk samples.
  task automatic stall(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.en = 1'b1;
        bus.pd_valid = 1'b0;
      end else begin
        bus.en = 1'b0;
        bus.pd_valid = 1'b1;
      end
      bus.pd_x = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.en = 1'b1;
    bus.pd_valid = 1'b0;
  endtask

  function automatic logic pat(int i, int k, logic start);
    return (i <= k) ? (start ^ 1'(i)) : (start ^ 1'(k));
  endfunction

  // One window with exactly k toggles, optionally with stalls between samples.
  task automatic win(int k, logic start, bit gaps);
    logic [1:0] g0;
    g0 = bus.gear;
    for (int i = 0; i < WIN; i++) begin
      if (gaps) stall($urandom_range(0, 3));
      if (gaps && i == WIN - 1) begin
        @(negedge clk);
        check("gap_no_early_close", int'(bus.gear), int'(g0));
      end
      send(pat(i, k, start));
    end
  endtask

  task automatic settle(bit gaps);
    for (int i = 0; i < SET; i++) begin
      if (gaps) stall($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic expect_now(string name, int g, int ki, int lk);
    @(negedge clk);
    check({name, "_gear"}, int'(bus.gear), g);
    check({name, "_ki"}, int'(bus.ki_step), ki);
    check({name, "_locked"}, int'(bus.locked), lk);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.pd_valid = 1'b0;
    bus.pd_x = 1'b0;
    do_reset(2);

    // Acquisition: WIDE -> MID -> NARROW
    exp_q.push_back(pack(GEAR_MID, 2500, 1'b0));
    win(15, 1'b0, 0);
    settle(0);
    exp_q.push_back(pack(GEAR_NARROW, 625, 1'b1));
    win(15, 1'b1, 0);
    expect_now("acq", 2, 625, 1);
    settle(0);

    // Saturation and T==TOGGLE_LO both keep NARROW
    win(15, 1'b0, 0);
    expect_now("sat", 2, 625, 1);
    win(2, 1'b1, 0);
    expect_now("t_eq_lo", 2, 625, 1);

    // Loss of lock: constant PD drops straight to WIDE
    exp_q.push_back(pack(GEAR_WIDE, 10000, 1'b0));
    win(0, 1'b1, 0);
    expect_now("lol", 0, 10000, 0);
    settle(0);

    // T == TOGGLE_HI steps down
    exp_q.push_back(pack(GEAR_MID, 2500, 1'b0));
    win(8, 1'b0, 0);
    settle(0);

    // Fresh reset, T == TOGGLE_HI-1 stays WIDE
    do_reset(2);
    win(7, 1'b0, 0);
    expect_now("t_hi_m1", 0, 10000, 0);
    check("t_hi_m1_chg", int'(bus.gear_chg), 0);

    // Reset in the middle of HOLD returns to WIDE/EVAL; next window evaluates at once
    exp_q.push_back(pack(GEAR_MID, 2500, 1'b0));
    win(15, 1'b1, 0);
    send(1'b0);
    send(1'b1);
    do_reset(1);
    exp_q.push_back(pack(GEAR_MID, 2500, 1'b0));
    win(15, 1'b0, 0);

    // Stalls in HOLD and mid-window give the same decision
    settle(1);
    exp_q.push_back(pack(GEAR_NARROW, 625, 1'b1));
    win(15, 1'b0, 1);
    expect_now("gap_acq", 2, 625, 1);
    settle(1);
    win(8, 1'b1, 1);
    expect_now("gap_sat", 2, 625, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
